// File: rtl/booth_mult_bcd.sv
// Signed radix-2 Booth multiplier with sign/magnitude split and
// iterative double-dabble conversion of the magnitude to packed BCD.
//
// Ports:
//   clk, reset (async, active-low)
//   start_i, num_a_i, num_b_i : request and signed operands
//   ready_o                   : idle, start_i is accepted
//   done_o                    : one-cycle pulse, results valid
//   product_o, sign_o         : signed product and its sign
//   magnitude_o               : absolute value of the product
//   bcd_o, bcd_ovf_o          : magnitude mod 10^DIGITS, overflow flag
module booth_mult_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      num_a_i,
    input  logic [WIDTH-1:0]      num_b_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [2*WIDTH-1:0]    product_o,
    output logic                  sign_o,
    output logic [2*WIDTH-1:0]    magnitude_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  bcd_ovf_o
);

    localparam int PW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_ABS,
        S_BCD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH:0]    a_q, a_d;
    logic [WIDTH:0]    m_q, m_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              qm1_q, qm1_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sgn_q, sgn_d;
    logic [PW-1:0]     mag_q, mag_d;
    logic [PW-1:0]     sh_q, sh_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic [PW-1:0]     product_q, product_d;
    logic              sign_q, sign_d;
    logic [PW-1:0]     magnitude_q, magnitude_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              bcd_ovf_q, bcd_ovf_d;

    logic [WIDTH:0]    sum;
    logic [PW-1:0]     product;
    logic [PW-1:0]     mag_abs;
    logic [BW-1:0]     adj;
    logic [3:0]        dig;
    logic [BW-1:0]     acc_next;
    logic              carry;

    always_comb begin
        // Booth recoding of the current multiplier bit pair
        sum = a_q;
        unique case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase

        // A's guard bit is pure sign; the low 2*WIDTH bits are exact
        product = {a_q[WIDTH-1:0], q_q};
        mag_abs = product[PW-1] ? (PW'(0) - product) : product;

        // Double-dabble: add 3 to every digit >= 5, then shift left
        adj = '0;
        dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = acc_q[4*i +: 4];
            adj[4*i +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
        end
        acc_next = {adj[BW-2:0], sh_q[PW-1]};
        // A bit leaving the top digit means the value reached 10^DIGITS
        carry = adj[BW-1];
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        m_d         = m_q;
        q_d         = q_q;
        qm1_d       = qm1_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        mag_d       = mag_q;
        sh_d        = sh_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        product_d   = product_q;
        sign_d      = sign_q;
        magnitude_d = magnitude_q;
        bcd_d       = bcd_q;
        bcd_ovf_d   = bcd_ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    m_d     = {num_a_i[WIDTH-1], num_a_i};
                    q_d     = num_b_i;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                a_d   = {sum[WIDTH], sum[WIDTH:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                sgn_d   = product[PW-1];
                mag_d   = mag_abs;
                sh_d    = mag_abs;
                acc_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = CW'(PW);
                state_d = S_BCD;
            end
            S_BCD: begin
                acc_d = acc_next;
                ovf_d = ovf_q | carry;
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d   = product;
                    sign_d      = sgn_q;
                    magnitude_d = mag_q;
                    bcd_d       = acc_next;
                    bcd_ovf_d   = ovf_q | carry;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            m_q         <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            mag_q       <= '0;
            sh_q        <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            product_q   <= '0;
            sign_q      <= 1'b0;
            magnitude_q <= '0;
            bcd_q       <= '0;
            bcd_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            m_q         <= m_d;
            q_q         <= q_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            mag_q       <= mag_d;
            sh_q        <= sh_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            product_q   <= product_d;
            sign_q      <= sign_d;
            magnitude_q <= magnitude_d;
            bcd_q       <= bcd_d;
            bcd_ovf_q   <= bcd_ovf_d;
        end
    end

    assign ready_o     = (state_q == S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign product_o   = product_q;
    assign sign_o      = sign_q;
    assign magnitude_o = magnitude_q;
    assign bcd_o       = bcd_q;
    assign bcd_ovf_o   = bcd_ovf_q;

endmodule

// File: tb/tb_booth_mult_bcd.sv
// Bench for booth_mult_bcd: DIGITS=5 and DIGITS=4 instances share
// stimulus; expected results are queued at start and popped at done.
module tb_booth_mult_bcd;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;

    logic        rdy0, done0, sign0, ovf0;
    logic [15:0] prod0, mag0;
    logic [19:0] bcd0;
    logic        rdy1, done1, sign1, ovf1;
    logic [15:0] prod1, mag1;
    logic [15:0] bcd1;

    booth_mult_bcd #(.WIDTH(W), .DIGITS(5)) u0 (
        .clk(clk), .reset(reset), .start_i(start),
        .num_a_i(a), .num_b_i(b),
        .ready_o(rdy0), .done_o(done0),
        .product_o(prod0), .sign_o(sign0),
        .magnitude_o(mag0), .bcd_o(bcd0),
        .bcd_ovf_o(ovf0)
    );

    booth_mult_bcd #(.WIDTH(W), .DIGITS(4)) u1 (
        .clk(clk), .reset(reset), .start_i(start),
        .num_a_i(a), .num_b_i(b),
        .ready_o(rdy1), .done_o(done1),
        .product_o(prod1), .sign_o(sign1),
        .magnitude_o(mag1), .bcd_o(bcd1),
        .bcd_ovf_o(ovf1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] prod;
        logic        sign;
        logic [15:0] mag;
        logic [19:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic [15:0] last_prod = '0;

    always @(posedge clk) begin
        if (done0) done_cnt++;
    end

    function automatic exp_t model(int x, int y, int d);
        exp_t   e;
        int     p;
        int     m;
        int     v;
        longint lim;
        p = x * y;
        m = (p < 0) ? -p : p;
        e.prod = p[15:0];
        e.sign = (p < 0);
        e.mag  = m[15:0];
        e.bcd  = '0;
        v = m;
        lim = 1;
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
            lim = lim * 10;
        end
        e.ovf = (longint'(m) >= lim);
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ready"}, 32'(rdy0), 32'd1);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_prod"}, 32'(prod0), 32'd0);
        chk({tag, "_sign"}, 32'(sign0), 32'd0);
        chk({tag, "_mag"}, 32'(mag0), 32'd0);
        chk({tag, "_bcd"}, 32'(bcd0), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf0), 32'd0);
        chk({tag, "_bcd4"}, 32'(bcd1), 32'd0);
    endtask

    task automatic run_op(int x, int y, bit disturb, string tag);
        exp_t e0;
        exp_t e1;
        int   k;
        int   base;
        bit   seen;
        base = done_cnt;
        chk({tag, "_ready"}, 32'(rdy0), 32'd1);
        q0.push_back(model(x, y, 5));
        q1.push_back(model(x, y, 4));
        a = x[7:0];
        b = y[7:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        seen = 1'b0;
        while (!seen && k < 200) begin
            if (done0) begin
                seen = 1'b1;
            end else begin
                if (disturb && k == 3) begin
                    start = 1'b1;
                    a = 8'd55;
                    b = 8'd99;
                end
                if (disturb && k == 4) start = 1'b0;
                if (k == 13) begin
                    chk({tag, "_hold"}, 32'(prod0),
                        32'(last_prod));
                end
                tick();
                k++;
            end
        end
        chk({tag, "_latency"}, 32'(k), 32'(3 * W + 2));
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        if (seen) begin
            chk({tag, "_prod"}, 32'(prod0), 32'(e0.prod));
            chk({tag, "_sign"}, 32'(sign0), 32'(e0.sign));
            chk({tag, "_mag"}, 32'(mag0), 32'(e0.mag));
            chk({tag, "_bcd"}, 32'(bcd0), 32'(e0.bcd));
            chk({tag, "_ovf"}, 32'(ovf0), 32'(e0.ovf));
            chk({tag, "_done4"}, 32'(done1), 32'd1);
            chk({tag, "_mag4"}, 32'(mag1), 32'(e1.mag));
            chk({tag, "_bcd4"}, 32'(bcd1),
                32'(e1.bcd[15:0]));
            chk({tag, "_ovf4"}, 32'(ovf1), 32'(e1.ovf));
            last_prod = e0.prod;
        end
        tick();
        chk({tag, "_after"}, 32'({rdy0, done0}), 32'd2);
        chk({tag, "_pulses"}, 32'(done_cnt - base), 32'd1);
    endtask

    initial begin
        int base;
        reset = 1'b0;
        tick();
        tick();
        chk_zero("in_reset");
        reset = 1'b1;
        tick();
        tick();
        chk_zero("idle");

        run_op(7, -3, 1'b0, "a7_bm3");
        run_op(-128, -128, 1'b0, "min_min");
        run_op(-128, 127, 1'b0, "min_max");
        run_op(100, 100, 1'b0, "ovf4");
        run_op(0, -5, 1'b1, "zero_dist");
        run_op(127, 127, 1'b0, "max_max");
        run_op(-1, 1, 1'b0, "m1_p1");

        base = done_cnt;
        q0.push_back(model(5, 6, 5));
        q1.push_back(model(5, 6, 4));
        a = 8'd5;
        b = 8'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_zero("abort");
        q0.delete();
        q1.delete();
        last_prod = '0;
        tick();
        tick();
        reset = 1'b1;
        chk("abort_nodone", 32'(done_cnt - base), 32'd0);
        run_op(-9, 11, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mult_bcd.md
BOOTH_MULT_BCD -- requirements
Module: booth_mult_bcd

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..16.
REQ-002 Parameter DIGITS, default 5, number of BCD digits produced; legal range 1..10.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request; accepted only on a rising edge where ready_o=1.
REQ-006 num_a_i  input  WIDTH  multiplicand, signed two's complement.
REQ-007 num_b_i  input  WIDTH  multiplier, signed two's complement.
REQ-008 ready_o  output  1  block idle, can accept start_i.
REQ-009 done_o  output  1  one-cycle pulse, all result outputs valid.
REQ-010 product_o  output  2*WIDTH  signed product, two's complement.
REQ-011 sign_o  output  1  1 when the product is negative.
REQ-012 magnitude_o  output  2*WIDTH  absolute value of the product, unsigned.
REQ-013 bcd_o  output  4*DIGITS  packed BCD of magnitude_o, digit 0 in bits [3:0].
REQ-014 bcd_ovf_o  output  1  1 when magnitude_o >= 10^DIGITS.

Function
REQ-015 FSM states IDLE, MULT, ABS, BCD, DONE; ready_o=1 only in IDLE, done_o=1 only in DONE.
REQ-016 IDLE with start_i=1: latch num_a_i into M, latch num_b_i into Q, clear accumulator A and Q(-1), load step counter with WIDTH, go to MULT.
REQ-017 IDLE with start_i=0: remain in IDLE.
REQ-018 A and M sign-extended to WIDTH+1 bits, so every operand pair, including -2^(WIDTH-1) x -2^(WIDTH-1), yields the exact product.
REQ-019 MULT, one radix-2 Booth step per cycle on {Q[0],Q(-1)}: 01 -> A+M; 10 -> A-M; 00/11 -> no add; then arithmetic right shift of {A,Q,Q(-1)}.
REQ-020 MULT lasts exactly WIDTH cycles, then go to ABS.
REQ-021 ABS, 1 cycle: form the 2*WIDTH-bit product; sign = product MSB; magnitude = product negated when sign=1, else product unchanged; go to BCD.
REQ-022 BCD: iterative double-dabble, one magnitude bit per cycle, MSB first; add 3 to each digit >=5 before each shift.
REQ-023 BCD lasts exactly 2*WIDTH cycles, then go to DONE.
REQ-024 bcd_o = magnitude mod 10^DIGITS; carries out of the top digit are discarded.
REQ-025 bcd_ovf_o = 1 iff magnitude >= 10^DIGITS.
REQ-026 DONE, 1 cycle: product_o, sign_o, magnitude_o, bcd_o and bcd_ovf_o update together on entry and are valid while done_o=1; then go to IDLE.
REQ-027 Latency: start accepted at edge E0 -> done_o high in cycle 3*WIDTH+2 after E0 (26 for WIDTH=8); ready_o high again in the following cycle.
REQ-028 Result outputs hold their last value until the next DONE; they do not change during MULT, ABS or BCD.
REQ-029 Operands are sampled only at accept; changes to num_a_i or num_b_i while busy have no effect.
REQ-030 start_i while ready_o=0 is ignored, not queued.
REQ-031 A zero product gives sign_o=0, never negative zero.

Reset
REQ-032 reset=0 forces, asynchronously: state IDLE; ready_o=1; done_o=0; product_o, sign_o, magnitude_o, bcd_o, bcd_ovf_o all 0; internal registers cleared.
REQ-033 reset asserted in any state, including mid-MULT or mid-BCD, aborts the operation with no done_o pulse.
REQ-034 The first accept is possible on the first rising edge after reset deasserts.

Verification
REQ-035 Reset, then idle -> ready_o=1, done_o=0, all result outputs 0.
REQ-036 WIDTH=8, a=7, b=-3 -> product_o=16'hFFEB, sign_o=1, magnitude_o=21, bcd_o=20'h00021, bcd_ovf_o=0, done_o exactly 26 cycles after accept.
REQ-037 a=-128, b=-128 -> product_o=16'h4000, sign_o=0, bcd_o=20'h16384; a=-128, b=127 -> product_o=16'hC080, sign_o=1, bcd_o=20'h16256.
REQ-038 DIGITS=4 instance, a=100, b=100 -> magnitude_o=10000, bcd_o=16'h0000, bcd_ovf_o=1.
REQ-039 a=0, b=-5 -> product_o=0, sign_o=0, bcd_o=0; start_i pulsed and operands changed during MULT -> no effect, single done_o pulse with the original result.
REQ-040 reset asserted at cycle 4 of MULT -> outputs 0 immediately, no done_o pulse; a new start after release completes normally with correct result.
